// File: rtl/mult_float_pipe.sv
// mult_float_pipe -- pipelined IEEE-754-format floating-point multiplier.
//
// Pipeline:
//   stage 1 : unpack, classify (zero / normal / Inf / NaN), fold special cases
//   stage 2 : (MAN_W+1)x(MAN_W+1) mantissa product, biased exponent sum
//   stage 3 : normalise, round, range-check, pack
//   LATENCY-3 further register stages delay the packed result.
// Subnormal inputs read as signed zero; subnormal results flush to signed zero.
// A result appears on the LATENCY-th ce-enabled edge, counting the edge that
// accepts the operands.
//
// Build option:
//   MULT_FLOAT_PIPE_RNE_EN  defined   -> round to nearest, ties to even
//                           undefined -> truncate (round toward zero)
//
// Parameters: EXP_W (exponent bits), MAN_W (stored mantissa bits),
//             LATENCY (3..8)
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   ce         in   clock enable; low freezes every register
//   in_valid   in   a/b carry an operand pair this cycle
//   a, b       in   W-bit operands
//   out_valid  out  result holds a completed product
//   result     out  W-bit product
module mult_float_pipe #(
    parameter int  EXP_W   = 8,
    parameter int  MAN_W   = 23,
    parameter int  LATENCY = 3,
    localparam int W       = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    output logic [W-1:0] result
);

    localparam int MW   = MAN_W + 1;          // mantissa with hidden bit
    localparam int PW   = 2 * MW;             // full product width
    localparam int EW2  = EXP_W + 2;          // signed exponent working width
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam int XTRA = LATENCY - 3;

    localparam logic signed [EW2-1:0] EXP_INF = EW2'(EMAX);
    localparam logic signed [EW2-1:0] EXP_ONE = EW2'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ---------------- stage 1: unpack / classify ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             za, zb, ia, ib, na, nb;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;

    // Exponent zero covers both true zero and subnormals (flushed).
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (ea == '1) && (ma == '0);
    assign ib = (eb == '1) && (mb == '0);
    assign na = (ea == '1) && (ma != '0);
    assign nb = (eb == '1) && (mb != '0);

    logic             s1_sign_d, s1_zero_d, s1_inf_d, s1_nan_d;
    logic             s1_sign_q, s1_zero_q, s1_inf_q, s1_nan_q;
    logic [EXP_W-1:0] s1_ea_q, s1_eb_q;
    logic [MW-1:0]    s1_ma_q, s1_mb_q;

    assign s1_sign_d = sa ^ sb;
    assign s1_zero_d = za | zb;
    assign s1_inf_d  = ia | ib;
    // NaN operands and Inf*zero both collapse to the canonical quiet NaN.
    assign s1_nan_d  = na | nb | (ia & zb) | (ib & za);

    // ---------------- stage 2: product / exponent sum ----------------
    logic                  s2_sign_q, s2_zero_q, s2_inf_q, s2_nan_q;
    logic [PW-1:0]         s2_prod_d, s2_prod_q;
    logic signed [EW2-1:0] s2_exp_d, s2_exp_q;

    assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
    assign s2_exp_d  = EW2'(s1_ea_q) + EW2'(s1_eb_q) - EW2'(BIAS);

    // ---------------- stage 3: normalise / round / pack ----------------
    logic [PW-1:0]         norm;
    logic signed [EW2-1:0] exp_n, exp_f;
    logic [MAN_W-1:0]      man_f;
    logic [W-1:0]          res_d;
    logic                  unused_bits;
`ifdef MULT_FLOAT_PIPE_RNE_EN
    logic                  rnd_up;
    logic [MAN_W:0]        man_r;
`endif

    always_comb begin
        // Product of two [1,2) values lies in [1,4): at most one shift left.
        norm  = s2_prod_q[PW-1] ? s2_prod_q : (s2_prod_q << 1);
        exp_n = s2_exp_q + EW2'(s2_prod_q[PW-1]);
        man_f = norm[PW-2 -: MAN_W];
        exp_f = exp_n;
`ifdef MULT_FLOAT_PIPE_RNE_EN
        // guard = norm[MAN_W], sticky = OR of everything below, lsb = norm[MAN_W+1]
        rnd_up = norm[MAN_W] & ((|norm[MAN_W-1:0]) | norm[MAN_W+1]);
        man_r  = {1'b0, man_f} + (MAN_W+1)'(rnd_up);
        if (man_r[MAN_W]) begin
            // Rounding rolled 1.11..1 over to 10.0: renormalise before range check.
            man_f = '0;
            exp_f = exp_n + EXP_ONE;
        end else begin
            man_f = man_r[MAN_W-1:0];
        end
`endif
        if (s2_nan_q)
            res_d = QNAN;
        else if (s2_inf_q)
            res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (s2_zero_q)
            res_d = {s2_sign_q, {(W-1){1'b0}}};
        else if (exp_f >= EXP_INF)
            res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (exp_f < EXP_ONE)
            res_d = {s2_sign_q, {(W-1){1'b0}}};
        else
            res_d = {s2_sign_q, exp_f[EXP_W-1:0], man_f};
    end

    // Hidden bit is implied after normalisation; the low product bits only
    // feed the rounding decision.
`ifdef MULT_FLOAT_PIPE_RNE_EN
    assign unused_bits = norm[PW-1];
`else
    assign unused_bits = ^{norm[PW-1], norm[MAN_W:0]};
`endif

    // ---------------- registers ----------------
    logic [LATENCY-1:0] vld_q;
    logic [W-1:0]       res_q [XTRA+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_ea_q   <= '0;
            s1_eb_q   <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_inf_q  <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_prod_q <= '0;
            s2_exp_q  <= '0;
            for (int i = 0; i <= XTRA; i++) res_q[i] <= '0;
        end else if (ce) begin
            vld_q     <= {vld_q[LATENCY-2:0], in_valid};
            s1_sign_q <= s1_sign_d;
            s1_zero_q <= s1_zero_d;
            s1_inf_q  <= s1_inf_d;
            s1_nan_q  <= s1_nan_d;
            s1_ea_q   <= ea;
            s1_eb_q   <= eb;
            s1_ma_q   <= {1'b1, ma};
            s1_mb_q   <= {1'b1, mb};
            s2_sign_q <= s1_sign_q;
            s2_zero_q <= s1_zero_q;
            s2_inf_q  <= s1_inf_q;
            s2_nan_q  <= s1_nan_q;
            s2_prod_q <= s2_prod_d;
            s2_exp_q  <= s2_exp_d;
            res_q[0]  <= res_d;
            for (int i = 1; i <= XTRA; i++) res_q[i] <= res_q[i-1];
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign result    = res_q[XTRA];

endmodule

// File: tb/tb_mult_float_pipe.sv
// Directed bench for mult_float_pipe: a LATENCY=3 and a LATENCY=5 instance
// share stimulus. Inputs change and outputs are sampled on the falling edge.
module tb_mult_float_pipe;

    logic        clk = 1'b0;
    logic        rst, ce, iv;
    logic [31:0] a, b;
    logic        ov3, ov5;
    logic [31:0] r3, r5;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mult_float_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(iv), .a(a), .b(b),
        .out_valid(ov3), .result(r3));

    mult_float_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(5)) dut5 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(iv), .a(a), .b(b),
        .out_valid(ov5), .result(r5));

`ifdef MULT_FLOAT_PIPE_RNE_EN
    localparam logic [31:0] P_RND   = 32'h4040_0003;
    localparam logic [31:0] P_CARRY = 32'h4000_0000;
    localparam logic [31:0] P_COVF  = 32'h7F80_0000;
`else
    localparam logic [31:0] P_RND   = 32'h4040_0002;
    localparam logic [31:0] P_CARRY = 32'h3FFF_FFFF;
    localparam logic [31:0] P_COVF  = 32'h7F7F_FFFF;
`endif

    typedef struct {
        logic        iv;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    localparam int N = 16;
    vec_t tab [N];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic [31:0] sp [4];

    initial begin
        // 2*3, bubble, rounding, overflow, Inf*0, -0*1, subnormal, ...
        tab[0]  = '{1'b1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
        tab[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tab[2]  = '{1'b1, 32'h3FC0_0001, 32'h4000_0001, P_RND};
        tab[3]  = '{1'b1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000};
        tab[4]  = '{1'b1, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
        tab[5]  = '{1'b1, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000};
        tab[6]  = '{1'b1, 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000};
        tab[7]  = '{1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        tab[8]  = '{1'b1, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000};
        tab[9]  = '{1'b1, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000};
        tab[10] = '{1'b1, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000};
        tab[11] = '{1'b1, 32'h8080_0000, 32'h0080_0000, 32'h8000_0000};
        // mantissas 1801*2^13 and 18631*2^9: product 2^47-2^22 (tie, odd lsb)
        tab[12] = '{1'b1, 32'h3FE1_2000, 32'h3F91_8E00, P_CARRY};
        tab[13] = '{1'b1, 32'h7F61_2000, 32'h3F91_8E00, P_COVF};
        tab[14] = '{1'b1, 32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000};
        tab[15] = '{1'b1, 32'hC040_0000, 32'hC000_0000, 32'h40C0_0000};

        sa = '{32'h4000_0000, 32'h3F80_0000, 32'hC000_0000, 32'h4040_0000};
        sb = '{32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000};
        sp = '{32'h40C0_0000, 32'h3F80_0000, 32'hC0C0_0000, 32'h4110_0000};

        // ---- reset state ----
        rst = 1'b0; ce = 1'b1; iv = 1'b0; a = '0; b = '0;
        #1 rst = 1'b1; iv = 1'b1; a = 32'h4000_0000; b = 32'h4040_0000;
        #1;
        chk("rst_vld3", 32'(ov3), 32'd0);
        chk("rst_res3", r3, 32'd0);
        chk("rst_vld5", 32'(ov5), 32'd0);
        chk("rst_res5", r5, 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_hold_vld3", 32'(ov3), 32'd0);
        chk("rst_hold_res3", r3, 32'd0);
        iv = 1'b0; rst = 1'b0;

        // ---- table stream, back-to-back ----
        for (int c = 0; c < N + 6; c++) begin
            int i3, i5;
            logic e3, e5;
            @(negedge clk);
            i3 = c - 3;
            i5 = c - 5;
            e3 = (i3 >= 0 && i3 < N) ? tab[(i3 >= 0 && i3 < N) ? i3 : 0].iv : 1'b0;
            e5 = (i5 >= 0 && i5 < N) ? tab[(i5 >= 0 && i5 < N) ? i5 : 0].iv : 1'b0;
            chk($sformatf("L3_vld_c%0d", c), 32'(ov3), 32'(e3));
            if (e3) chk($sformatf("L3_res_v%0d", i3), r3, tab[i3].p);
            chk($sformatf("L5_vld_c%0d", c), 32'(ov5), 32'(e5));
            if (e5) chk($sformatf("L5_res_v%0d", i5), r5, tab[i5].p);
            if (c < N) begin
                iv = tab[c].iv; a = tab[c].a; b = tab[c].b;
            end else begin
                iv = 1'b0;
            end
        end

        // ---- ce stall: 4 pairs, ce low on two edges while in flight ----
        for (int n = 0; n < 10; n++) begin
            int k;
            logic ev;
            @(negedge clk);
            ev = (n >= 3 && n <= 8);
            k  = (n <= 5) ? 0 : n - 5;
            chk($sformatf("stall_vld_n%0d", n), 32'(ov3), 32'(ev));
            if (ev) chk($sformatf("stall_res_n%0d", n), r3, sp[k]);
            ce = !(n == 3 || n == 4);
            if (n <= 5) begin
                iv = 1'b1;
                a  = sa[(n > 3) ? 3 : n];
                b  = sb[(n > 3) ? 3 : n];
            end else begin
                iv = 1'b0;
            end
        end
        ce = 1'b1;

        // ---- reset mid-flight ----
        @(negedge clk); iv = 1'b1; a = 32'h4040_0000; b = 32'h4040_0000;
        @(negedge clk); a = 32'h3F80_0000; b = 32'h4000_0000;
        @(negedge clk); a = 32'h4000_0000; b = 32'h4000_0000;
        @(negedge clk);
        chk("mid_pre_vld", 32'(ov3), 32'd1);
        chk("mid_pre_res", r3, 32'h4110_0000);
        ce = 1'b0; rst = 1'b1; a = 32'h4100_0000;
        #1;
        chk("mid_rst_vld3", 32'(ov3), 32'd0);
        chk("mid_rst_res3", r3, 32'd0);
        chk("mid_rst_vld5", 32'(ov5), 32'd0);
        chk("mid_rst_res5", r5, 32'd0);
        @(negedge clk);
        chk("mid_hold_vld", 32'(ov3), 32'd0);
        rst = 1'b0; ce = 1'b1; iv = 1'b1; a = 32'hC000_0000; b = 32'h3F80_0000;
        for (int n = 5; n <= 9; n++) begin
            @(negedge clk);
            iv = 1'b0;
            chk($sformatf("post_vld3_n%0d", n), 32'(ov3), 32'(n == 7));
            if (n == 7) chk("post_res3", r3, 32'hC000_0000);
            chk($sformatf("post_vld5_n%0d", n), 32'(ov5), 32'(n == 9));
            if (n == 9) chk("post_res5", r5, 32'hC000_0000);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mult_float_pipe.md
MULT_FLOAT_PIPE -- requirements
Module: mult_float_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning stored mantissa field width; W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have parameter LATENCY, default 3, meaning cycles from input acceptance to result; legal range 3..8.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  asynchronous active-high reset.
REQ-007 Port: ce  input  1  clock enable; low freezes all state.
REQ-008 Port: in_valid  input  1  a/b hold an operand pair this cycle.
REQ-009 Port: a  input  W  IEEE-754-format operand A.
REQ-010 Port: b  input  W  IEEE-754-format operand B.
REQ-011 Port: out_valid  output  1  result holds a completed product.
REQ-012 Port: result  output  W  product a*b.

Function
REQ-013 The block SHALL accept an operand pair on a rising edge where ce=1 and in_valid=1; in_valid is ignored when ce=0.
REQ-014 The block SHALL present the product on result with out_valid=1 exactly LATENCY ce-enabled edges after acceptance; bubbles (in_valid=0) propagate as out_valid=0.
REQ-015 The block SHALL be fully pipelined: one new pair per ce-enabled cycle, no backpressure.
REQ-016 The block SHALL freeze every pipeline register, including the valid chain, while ce=0; outputs hold their values.
REQ-017 Stage 1 SHALL unpack and classify operands (zero, normal, Inf, NaN); stage 2 SHALL form the (MAN_W+1)x(MAN_W+1) mantissa product and exponent sum; the final stage SHALL normalise, round and pack; LATENCY-3 extra register stages SHALL follow the final stage.
REQ-018 Result sign SHALL be sign(a) XOR sign(b) for all non-NaN results.
REQ-019 Subnormal inputs SHALL be treated as zero of the same sign; subnormal results SHALL be flushed to signed zero.
REQ-020 Biased exponent = ea+eb-BIAS (BIAS=2^(EXP_W-1)-1), +1 when the product MSB is set, computed at width EXP_W+2 signed.
REQ-021 Biased exponent >= 2^EXP_W-1 after rounding SHALL produce signed Inf; <= 0 SHALL produce signed zero.
REQ-022 Any NaN input, or Inf*zero, SHALL produce canonical quiet NaN: sign 0, exponent all ones, mantissa MSB 1, other bits 0 (0x7FC00000 at defaults).
REQ-023 Inf times nonzero non-NaN SHALL produce signed Inf; zero times finite SHALL produce signed zero.
REQ-024 Mantissa carry-out from rounding SHALL renormalise (mantissa 0, exponent +1) before the overflow check.

Reset
REQ-025 While rst=1, out_valid, result and all internal valid bits SHALL be 0, regardless of clk and ce.
REQ-026 Pairs in flight when rst asserts SHALL be discarded; no out_valid SHALL be produced for them after rst deasserts.
REQ-027 The first pair accepted after rst deasserts SHALL complete with normal LATENCY.

Configuration
REQ-028 With macro MULT_FLOAT_PIPE_RNE_EN defined, the final stage SHALL round to nearest, ties to even, using guard and sticky bits of the full product.
REQ-029 Without MULT_FLOAT_PIPE_RNE_EN, the final stage SHALL truncate (round toward zero) and omit the rounding incrementer.

Verification
REQ-030 Basic: a=0x40000000, b=0x40400000, in_valid=1, ce=1 -> result=0x40C00000, out_valid=1 exactly 3 cycles later (LATENCY=3).
REQ-031 Rounding: a=0x3FC00001, b=0x40000001 -> 0x40400003 with MULT_FLOAT_PIPE_RNE_EN, 0x40400002 without.
REQ-032 Specials: 0x7F000000*0x7F000000 -> 0x7F800000; 0x7F800000*0x00000000 -> 0x7FC00000; 0x80000000*0x3F800000 -> 0x80000000; 0x00400000*0x3F800000 -> 0x00000000.
REQ-033 Stall: stream 4 back-to-back pairs, drop ce for 2 cycles mid-flight -> all 4 results in order, each out_valid delayed by exactly 2 cycles, values unchanged during stall.
REQ-034 Reset mid-flight: accept 2 pairs, assert rst for 1 cycle before completion -> out_valid=0, result=0 immediately; no result for the flushed pairs; next pair completes after 3 cycles.
REQ-035 LATENCY=5 build: repeat REQ-030 -> same value after exactly 5 cycles, with a 1-cycle bubble preserved in the output stream.
